// File: rtl/redis_cache_host_seq.sv
// Host-side sequencer for the redis cache register block: writes KEY/DATA/CTRL,
// polls CTRL.busy, reads DATA back and returns it on a valid/ready response port.
module redis_cache_host_seq #(
  parameter int unsigned PollLimit = 1024,
  parameter int unsigned OpWidth   = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [OpWidth-1:0] cmd_op_i,
  input  logic [31:0]        cmd_key_i,
  input  logic [63:0]        cmd_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [63:0]        rsp_data_o,
  output logic               rsp_err_o,
  output logic               bus_req_o,
  input  logic               bus_gnt_i,
  output logic               bus_we_o,
  output logic [3:0]         bus_addr_o,
  output logic [31:0]        bus_wdata_o,
  output logic [3:0]         bus_be_o,
  input  logic               bus_rvalid_i,
  input  logic [31:0]        bus_rdata_i
);

  localparam int unsigned    CntW    = $clog2(PollLimit + 1);
  localparam logic [CntW-1:0] PollMax = CntW'(PollLimit);

  localparam logic [3:0] AddrDataLo = 4'h0;
  localparam logic [3:0] AddrDataHi = 4'h4;
  localparam logic [3:0] AddrKey    = 4'h8;
  localparam logic [3:0] AddrCtrl   = 4'hC;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_KEY, S_WR_DLO, S_WR_DHI, S_WR_CTRL, S_POLL, S_RD_DLO, S_RD_DHI, S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic               wait_rv_q, wait_rv_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [OpWidth-1:0] op_q, op_d;
  logic [63:0]        data_q, data_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [63:0]        rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               bus_req_q, bus_req_d;
  logic               bus_we_q, bus_we_d;
  logic [3:0]         bus_addr_q, bus_addr_d;
  logic [31:0]        bus_wdata_q, bus_wdata_d;
  logic               launch;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      wait_rv_q   <= 1'b0;
      cnt_q       <= '0;
      op_q        <= '0;
      data_q      <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_rv_q   <= wait_rv_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      data_q      <= data_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_rv_d   = wait_rv_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    data_d      = data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    launch      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          state_d    = S_WR_KEY;
          op_d       = cmd_op_i;
          data_d     = cmd_data_i;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          launch     = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        // rvalid is only honoured once the grant has been taken
        if (bus_req_q && bus_gnt_i) begin
          bus_req_d = 1'b0;
          wait_rv_d = 1'b1;
        end else if (wait_rv_q && bus_rvalid_i) begin
          wait_rv_d = 1'b0;
          case (state_q)
            S_WR_KEY:  begin state_d = S_WR_DLO;  launch = 1'b1; end
            S_WR_DLO:  begin state_d = S_WR_DHI;  launch = 1'b1; end
            S_WR_DHI:  begin state_d = S_WR_CTRL; launch = 1'b1; end
            S_WR_CTRL: begin state_d = S_POLL;    launch = 1'b1; end
            S_POLL: begin
              if (!bus_rdata_i[0]) begin
                state_d = S_RD_DLO;
                launch  = 1'b1;
              end else if (cnt_q < PollMax) begin
                launch = 1'b1;
              end else begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_data_d  = '0;
              end
            end
            S_RD_DLO: begin
              rsp_data_d[31:0] = bus_rdata_i;
              state_d          = S_RD_DHI;
              launch           = 1'b1;
            end
            S_RD_DHI: begin
              rsp_data_d[63:32] = bus_rdata_i;
              state_d           = S_RESP;
              rsp_valid_d       = 1'b1;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase

    // Load the request for the state being entered (or re-entered for a poll)
    if (launch) begin
      bus_req_d   = 1'b1;
      bus_we_d    = 1'b1;
      bus_wdata_d = '0;
      case (state_d)
        S_WR_KEY:  begin bus_addr_d = AddrKey;    bus_wdata_d = cmd_key_i;      end
        S_WR_DLO:  begin bus_addr_d = AddrDataLo; bus_wdata_d = data_q[31:0];   end
        S_WR_DHI:  begin bus_addr_d = AddrDataHi; bus_wdata_d = data_q[63:32];  end
        S_WR_CTRL: begin bus_addr_d = AddrCtrl;   bus_wdata_d = 32'({op_q, 1'b1}); end
        S_POLL: begin
          bus_we_d   = 1'b0;
          bus_addr_d = AddrCtrl;
          cnt_d      = cnt_q + CntW'(1);
        end
        S_RD_DLO: begin bus_we_d = 1'b0; bus_addr_d = AddrDataLo; end
        S_RD_DHI: begin bus_we_d = 1'b0; bus_addr_d = AddrDataHi; end
        default:  begin bus_req_d = 1'b0; bus_we_d = 1'b0; end
      endcase
    end

    cmd_ready_d = (state_d == S_IDLE);
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_be_o    = 4'hF;

endmodule

// File: tb/tb_redis_cache_host_seq.sv
// Directed bench for redis_cache_host_seq: a register-bus responder model logs
// every granted transaction; commands are checked against hand-computed results.
module tb_redis_cache_host_seq;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [2:0]  cmd_op_i;
  logic [31:0] cmd_key_i;
  logic [63:0] cmd_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_data_o;
  logic        rsp_err_o;
  logic        bus_req_o;
  logic        bus_gnt_i;
  logic        bus_we_o;
  logic [3:0]  bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  redis_cache_host_seq #(.PollLimit(4), .OpWidth(3)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_key_i(cmd_key_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // responder knobs and transaction log
  int          gnt_delay = 0;
  int          busy_left = 0;
  int          always_busy = 0;
  int          rst_at = -1;
  logic [31:0] dlo = '0;
  logic [31:0] dhi = '0;
  logic [36:0] log_q [64];
  int          txn_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int n_reads(input logic [3:0] a);
    int n = 0;
    for (int i = 0; i < txn_cnt && i < 64; i++)
      if (log_q[i][36] == 1'b0 && log_q[i][35:32] == a) n++;
    return n;
  endfunction

  // register-bus slave: grants after gnt_delay cycles, rvalid the cycle after grant
  initial begin
    int          gnt_cnt;
    logic        rv_pend;
    logic [31:0] rv_data;
    logic [31:0] tmp;
    logic [36:0] snap;
    logic [36:0] cur;
    gnt_cnt = 0; rv_pend = 1'b0; rv_data = '0; snap = '0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    forever begin
      @(negedge clk);
      bus_gnt_i = 1'b0;
      if (rv_pend) begin
        bus_rvalid_i = 1'b1; bus_rdata_i = rv_data; rv_pend = 1'b0;
      end else begin
        bus_rvalid_i = 1'b0; bus_rdata_i = $urandom;
      end
      if (bus_req_o) begin
        cur = {bus_we_o, bus_addr_o, bus_wdata_o};
        if (gnt_cnt == 0) snap = cur;
        else chk("bus_stable", 64'(cur), 64'(snap));
        if (gnt_cnt >= gnt_delay) begin
          bus_gnt_i = 1'b1;
          chk("bus_be", 64'(bus_be_o), 64'hF);
          if (txn_cnt < 64) log_q[txn_cnt] = cur;
          txn_cnt++;
          rv_data = '0;
          if (!bus_we_o) begin
            tmp = $urandom;
            case (bus_addr_o)
              4'hC: begin
                if (always_busy != 0) tmp[0] = 1'b1;
                else if (busy_left > 0) begin tmp[0] = 1'b1; busy_left--; end
                else tmp[0] = 1'b0;
                rv_data = tmp;
              end
              4'h0: rv_data = dlo;
              4'h4: rv_data = dhi;
              default: rv_data = tmp;
            endcase
          end
          rv_pend = 1'b1;
          gnt_cnt = 0;
          if (txn_cnt == rst_at) rst_i = 1'b1;
        end else begin
          gnt_cnt++;
        end
      end
    end
  end

  task automatic do_cmd(input logic [2:0] op, input logic [31:0] key, input logic [63:0] data);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready_o && n < 200) begin @(negedge clk); n++; end
    chk("cmd_ready_idle", 64'(cmd_ready_o), 64'd1);
    txn_cnt = 0;
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_key_i = key; cmd_data_i = data;
    @(negedge clk);
    acc_cyc = cyc;
    cmd_valid_i = 1'b0;
    cmd_op_i = 3'($urandom); cmd_key_i = $urandom; cmd_data_i = {$urandom, $urandom};
    chk("cmd_ready_busy", 64'(cmd_ready_o), 64'd0);
  endtask

  task automatic wait_rsp(input int hold, input int exp_lat, input logic [63:0] exp_data,
                          input logic exp_err);
    int n = 0;
    while (!rsp_valid_o && n < 500) begin @(negedge clk); n++; end
    chk("rsp_seen", 64'(rsp_valid_o), 64'd1);
    chk("rsp_latency", 64'(cyc - acc_cyc), 64'(exp_lat));
    chk("rsp_data", rsp_data_o, exp_data);
    chk("rsp_err", 64'(rsp_err_o), 64'(exp_err));
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_hold_valid", 64'(rsp_valid_o), 64'd1);
      chk("rsp_hold_data", rsp_data_o, exp_data);
      chk("rsp_hold_ready", 64'(cmd_ready_o), 64'd0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("rsp_drop", 64'(rsp_valid_o), 64'd0);
    chk("cmd_ready_after", 64'(cmd_ready_o), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [36:0] exp1 [7];
    int n;
    exp1 = '{ {1'b1, 4'h8, 32'hDEAD_BEEF}, {1'b1, 4'h0, 32'h89AB_CDEF},
              {1'b1, 4'h4, 32'h0123_4567}, {1'b1, 4'hC, 32'h0000_0003},
              {1'b0, 4'hC, 32'h0}, {1'b0, 4'h0, 32'h0}, {1'b0, 4'h4, 32'h0} };
    rst_i = 1'b1; cmd_valid_i = 1'b0; rsp_ready_i = 1'b0;
    cmd_op_i = '0; cmd_key_i = '0; cmd_data_i = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rsp_data", rsp_data_o, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err_o), 64'd0);
    chk("rst_bus", 64'({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o}), 64'd0);

    // immediate completion
    dlo = 32'h1111_2222; dhi = 32'h3333_4444;
    do_cmd(3'd1, 32'hDEAD_BEEF, 64'h0123_4567_89AB_CDEF);
    wait_rsp(1, 14, 64'h3333_4444_1111_2222, 1'b0);
    chk("t1_txn_cnt", 64'(txn_cnt), 64'd7);
    for (int i = 0; i < 7; i++) chk($sformatf("t1_txn%0d", i), 64'(log_q[i]), 64'(exp1[i]));

    // busy polling: three busy reads then done
    busy_left = 3; dlo = 32'hA5A5_0001; dhi = 32'h5A5A_0002;
    do_cmd(3'd2, 32'h0000_1234, 64'hFEDC_BA98_7654_3210);
    wait_rsp(1, 20, 64'h5A5A_0002_A5A5_0001, 1'b0);
    chk("t2_ctrl_reads", 64'(n_reads(4'hC)), 64'd4);
    chk("t2_dlo_reads", 64'(n_reads(4'h0)), 64'd1);
    chk("t2_dhi_reads", 64'(n_reads(4'h4)), 64'd1);
    chk("t2_ctrl_wdata", 64'(log_q[3]), 64'({1'b1, 4'hC, 32'h0000_0005}));

    // poll timeout at the limit of 4
    always_busy = 1;
    do_cmd(3'd7, 32'h0BAD_F00D, 64'h1);
    wait_rsp(1, 16, 64'd0, 1'b1);
    chk("t3_ctrl_reads", 64'(n_reads(4'hC)), 64'd4);
    chk("t3_data_reads", 64'(n_reads(4'h0) + n_reads(4'h4)), 64'd0);
    always_busy = 0;

    // grant delay and response backpressure
    gnt_delay = 3; dlo = 32'hCAFE_0000; dhi = 32'hBEEF_FFFF;
    do_cmd(3'd3, 32'h1357_9BDF, 64'h2468_ACE0_1357_9BDF);
    wait_rsp(5, 35, 64'hBEEF_FFFF_CAFE_0000, 1'b0);
    chk("t4_txn_cnt", 64'(txn_cnt), 64'd7);
    chk("t4_ctrl_wdata", 64'(log_q[3]), 64'({1'b1, 4'hC, 32'h0000_0007}));
    gnt_delay = 0;

    // reset right after the DATA-hi write is granted
    rst_at = 3;
    do_cmd(3'd4, 32'h7777_8888, 64'h9999_AAAA_BBBB_CCCC);
    n = 0;
    while (!rst_i && n < 100) begin @(posedge clk); n++; end
    chk("t5_rst_seen", 64'(rst_i), 64'd1);
    #1;
    rst_at = -1;
    rst_i = 1'b0;
    chk("t5_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("t5_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("t5_rsp_data", rsp_data_o, 64'd0);
    chk("t5_bus", 64'({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o}), 64'd0);
    repeat (3) @(negedge clk);
    chk("t5_late_rv_req", 64'(bus_req_o), 64'd0);
    chk("t5_late_rv_ready", 64'(cmd_ready_o), 64'd1);
    chk("t5_txn_cnt", 64'(txn_cnt), 64'd3);
    dlo = 32'h0F0F_0F0F; dhi = 32'hF0F0_F0F0;
    do_cmd(3'd5, 32'h4242_4242, 64'h1);
    wait_rsp(1, 14, 64'hF0F0_F0F0_0F0F_0F0F, 1'b0);
    chk("t5_txn0", 64'(log_q[0]), 64'({1'b1, 4'h8, 32'h4242_4242}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
